// File: rtl/fnd_scan_ctrl_pkg.sv
// Shared constants, conversion FSM states and input saturation helper
// for the 4-digit FND scan controller.
package fnd_pkg;

    localparam int FND_DIGITS    = 4;
    localparam int FND_MAX_VALUE = 9999;
    localparam int BIN_W         = 14;
    localparam int BCD_W         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    function automatic logic [BIN_W-1:0] saturate(input logic [BIN_W-1:0] v);
        return (v > BIN_W'(FND_MAX_VALUE)) ? BIN_W'(FND_MAX_VALUE) : v;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Value handshake between the producer and the FND scan controller.
interface fnd_scan_ctrl_if;
    import fnd_pkg::*;

    logic             i_valid;
    logic [BIN_W-1:0] i_value;
    logic             o_ready;

    modport master (output i_valid, output i_value, input  o_ready);
    modport slave  (input  i_valid, input  i_value, output o_ready);

endinterface

// File: rtl/fnd_scan_ctrl_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, 14 steps per value,
// result held in DONE for one cycle so the caller can capture it.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    conv_state_t      state_reg, state_next;
    logic [BIN_W-1:0] bin_reg, bin_next;
    logic [BCD_W-1:0] bcd_reg, bcd_next;
    logic [3:0]       iter_reg, iter_next;
    logic [BCD_W-1:0] bcd_adj;

    genvar gi;
    generate
        for (gi = 0; gi < FND_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            iter_reg  <= '0;
        end else begin
            state_reg <= state_next;
            bin_reg   <= bin_next;
            bcd_reg   <= bcd_next;
            iter_reg  <= iter_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bin_next   = bin_reg;
        bcd_next   = bcd_reg;
        iter_next  = iter_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    bin_next   = bin;
                    bcd_next   = '0;
                    iter_next  = '0;
                    state_next = CONV;
                end
            end
            CONV: begin
                {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;
                iter_next = iter_reg + 4'd1;
                if (iter_reg == 4'(BIN_W - 1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign bcd  = bcd_reg;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// FND scan controller: accepts a value, converts it to BCD, holds it for display
// and scans the four digits with leading-zero blanking.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter int BLANK_LZ = 1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    fnd_scan_ctrl_if.slave      bus,
    output logic [1:0]          o_cnt4,
    output logic [3:0]          o_bcd,
    output logic                o_blank
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic             conv_start;
    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic [BCD_W-1:0] display_reg;
    logic [PRE_W-1:0] pre_reg;
    logic [1:0]       cnt_reg;
    logic [FND_DIGITS-1:0] digit_zero;
    logic [FND_DIGITS-1:0] upper_zero;
    logic             zero_run;

    assign bus.o_ready = !conv_busy;
    assign conv_start  = bus.i_valid && bus.o_ready;

    bin2bcd_seq u_bin2bcd (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .start (conv_start),
        .bin   (saturate(bus.i_value)),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            display_reg <= '0;
        end else if (conv_done) begin
            display_reg <= conv_bcd;
        end
    end

    // Scan runs freely; the slot index advances on the last prescaler count.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pre_reg <= '0;
            cnt_reg <= '0;
        end else if (pre_reg == PRE_W'(SCAN_DIV - 1)) begin
            pre_reg <= '0;
            cnt_reg <= cnt_reg + 2'd1;
        end else begin
            pre_reg <= pre_reg + PRE_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FND_DIGITS; gi++) begin : g_zero
            assign digit_zero[gi] = (display_reg[gi*4 +: 4] == 4'd0);
        end
    endgenerate

    // upper_zero[k]: digits k..3 are all zero
    always_comb begin
        upper_zero = '0;
        zero_run   = 1'b1;
        for (int k = FND_DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run && digit_zero[k];
            upper_zero[k] = zero_run;
        end
    end

    assign o_cnt4  = cnt_reg;
    assign o_bcd   = display_reg[cnt_reg*4 +: 4];
    assign o_blank = (BLANK_LZ != 0) && (cnt_reg != 2'd0) && upper_zero[cnt_reg];

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with SCAN_DIV=4: table of values with expected
// digits and blanking, plus busy-ignore, wrap and mid-conversion reset sequences.
module tb_fnd_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] o_cnt4;
    logic [3:0] o_bcd;
    logic       o_blank;
    int         n_vec = 0;
    int         n_err = 0;
    int         edge_cnt;

    fnd_scan_ctrl_if bus ();

    fnd_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave),
        .o_cnt4    (o_cnt4),
        .o_bcd     (o_bcd),
        .o_blank   (o_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; the expected slot is (edges/4) mod 4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [1:0] model_cnt();
        return 2'((edge_cnt / 4) % 4);
    endfunction

    typedef struct {
        logic [13:0] value;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_blank;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired, got timeout expected event", name);
    endtask

    task automatic wait_slot(input int k);
        int guard = 0;
        while (model_cnt() != 2'(k) && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) timeout("wait_slot");
    endtask

    task automatic check_slots(input logic [15:0] exp_bcd, input logic [3:0] exp_blank);
        for (int k = 0; k < 4; k++) begin
            wait_slot(k);
            check($sformatf("slot%0d_cnt4", k), o_cnt4, k);
            check($sformatf("slot%0d_bcd", k), o_bcd, exp_bcd[k*4 +: 4]);
            check($sformatf("slot%0d_blank", k), o_blank, exp_blank[k]);
        end
    endtask

    // One-cycle request; optionally injects a second request inject_at cycles after E0.
    task automatic convert(input logic [13:0] v, input int inject_at,
                           input logic [13:0] inject_v, output int low);
        int guard = 0;
        low = 0;
        @(negedge clk);
        check("ready_before", bus.o_ready, 1);
        bus.i_valid = 1'b1;
        bus.i_value = v;
        @(negedge clk);
        bus.i_valid = 1'b0;
        while (bus.o_ready == 1'b0 && guard < 100) begin
            low++;
            guard++;
            if (low == inject_at) begin
                bus.i_valid = 1'b1;
                bus.i_value = inject_v;
            end else begin
                bus.i_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        if (guard >= 100) timeout("ready_return");
    endtask

    initial begin
        int low;
        int still_low;
        int guard;

        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_value = '0;

        vecs[0] = '{14'd1234,  16'h1234, 4'b0000};
        vecs[1] = '{14'd7,     16'h0007, 4'b1110};
        vecs[2] = '{14'd0,     16'h0000, 4'b1110};
        vecs[3] = '{14'd305,   16'h0305, 4'b1000};
        vecs[4] = '{14'd9999,  16'h9999, 4'b0000};
        vecs[5] = '{14'd1000,  16'h1000, 4'b0000};
        vecs[6] = '{14'd12000, 16'h9999, 4'b0000};
        vecs[7] = '{14'd10,    16'h0010, 4'b1100};
        vecs[8] = '{14'd16383, 16'h9999, 4'b0000};

        repeat (3) @(negedge clk);
        check("rst_ready", bus.o_ready, 1);
        check("rst_cnt4", o_cnt4, 0);
        check("rst_bcd", o_bcd, 0);
        check("rst_blank", o_blank, 0);
        rst_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            check($sformatf("scan_seq_%0d", n), o_cnt4, (n / 4) % 4);
        end

        for (int i = 0; i < 9; i++) begin
            convert(vecs[i].value, -1, 14'd0, low);
            check($sformatf("busy_len_v%0d", vecs[i].value), low, 15);
            check_slots(vecs[i].exp_bcd, vecs[i].exp_blank);
        end

        // Wrap 3->0 switches o_bcd from thousands to ones in the same cycle.
        convert(14'd1234, -1, 14'd0, low);
        check("busy_len_wrap", low, 15);
        guard = 0;
        while (edge_cnt % 16 != 15 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) timeout("wrap_align");
        check("wrap_pre_cnt4", o_cnt4, 3);
        check("wrap_pre_bcd", o_bcd, 1);
        @(negedge clk);
        check("wrap_post_cnt4", o_cnt4, 0);
        check("wrap_post_bcd", o_bcd, 4);

        // Saturating value with a request at E0+5 that must be ignored.
        convert(14'd12000, 5, 14'd42, low);
        check("busy_len_sat", low, 15);
        check_slots(16'h9999, 4'b0000);
        still_low = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.o_ready == 1'b0) still_low++;
        end
        check("no_second_conv", still_low, 0);
        check_slots(16'h9999, 4'b0000);

        // Reset asserted before E7 aborts the conversion.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_value = 14'd1234;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ready", bus.o_ready, 1);
        check("abort_cnt4", o_cnt4, 0);
        check("abort_bcd", o_bcd, 0);
        check("abort_blank", o_blank, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        still_low = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.o_ready == 1'b0) still_low++;
        end
        check("abort_ready_after", still_low, 0);
        check_slots(16'h0000, 4'b1110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
